fir_channel_scheduler: RTL and testbench
========================================

FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 Parameter NUM_FILTERS, default 4: filter banks swept per sample; legal range 1..16.
REQ-002 Parameter PIPE_LAT, default 3: MAC pipeline drain cycles after the last tap; legal range 1..15.
REQ-003 clk  in  1  sole clock; every register updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 audio_en  in  1  run enable, from audio_control[0].
REQ-006 taps_per_filter  in  8  taps per filter, from the CPU register.
REQ-007 l_data_en, r_data_en  in  1 each  one-cycle new-sample strobes.
REQ-008 l_data_in, r_data_in  in  24 each  PCM samples, valid with their strobes.
REQ-009 mac_start  out  1  one-cycle pulse that clears the shared MAC accumulators.
REQ-010 mac_chan  out  1  channel served by the MAC: 0=left, 1=right.
REQ-011 mac_filter  out  4  current filter index.
REQ-012 mac_tap  out  8  current tap index.
REQ-013 mac_tap_valid  out  1  mac_filter/mac_tap are valid this cycle.
REQ-014 mac_sample  out  24  held sample of the channel being served.
REQ-015 l_done, r_done  out  1 each  one-cycle strobes; the MAC outputs for that channel are final.
REQ-016 busy  out  1  FSM not in IDLE.
REQ-017 overrun  out  2  sticky flags: [0]=left, [1]=right.
REQ-018 overrun_cnt  out  8  saturating overrun event count (see Configuration).

Function
REQ-019 A strobe in any state shall latch its sample into that channel's holding register and set the channel's pending flag.
REQ-020 A strobe while its channel is already pending shall overwrite the held sample and set the channel's overrun bit.
REQ-021 FSM states are IDLE, LOAD, RUN, DRAIN, DONE.
REQ-022 IDLE -> LOAD when audio_en=1 and any pending flag is set; the selected channel's pending flag clears on this transition.
REQ-023 Arbitration: if only one channel is pending, that channel is selected; if both are pending, the channel opposite last_served is selected; last_served resets to right, so left wins first.
REQ-024 A strobe for the selected channel arriving in the same cycle as its pending clear shall leave pending set (the new sample is queued).
REQ-025 The held sample shall be copied into mac_sample on entry to LOAD and stay stable until the next LOAD, independent of later strobes.
REQ-026 LOAD is 1 cycle: mac_start=1; taps_per_filter is captured as T, with T=0 treated as T=1.
REQ-027 RUN is NUM_FILTERS*T cycles with mac_tap_valid=1, starting at filter 0, tap 0.
REQ-028 In RUN, mac_tap increments each cycle; after tap T-1, mac_tap wraps to 0 and mac_filter increments.
REQ-029 After filter NUM_FILTERS-1, tap T-1, the FSM goes to DRAIN.
REQ-030 DRAIN is PIPE_LAT cycles with mac_tap_valid=0.
REQ-031 DONE is 1 cycle: it pulses the served channel's done strobe, updates last_served, and returns to IDLE.
REQ-032 Latency from the strobe (IDLE, cycle 0) to done shall be 2+NUM_FILTERS*T+PIPE_LAT cycles.
REQ-033 audio_en=0 in any state: the FSM goes to IDLE next cycle, both pending flags clear, no done strobe is issued, and the overrun flags clear; overrun_cnt holds.
REQ-034 Strobes while audio_en=0 shall be ignored.
REQ-035 mac_chan, mac_filter and mac_tap shall hold their last values outside RUN.

Reset
REQ-036 While reset=1, on the next edge: state=IDLE, pending=0, last_served=right, all outputs 0, including mac_sample, overrun and overrun_cnt.
REQ-037 reset asserted mid-operation shall abort the current job with no done strobe.

Configuration
REQ-038 Macro SCHED_OVERRUN_CNT_EN defined: overrun_cnt increments once per overrun event and saturates at 255; simultaneous left and right events in one cycle add 2, saturating; the count clears only on reset.
REQ-039 Macro SCHED_OVERRUN_CNT_EN undefined: overrun_cnt is constant 0 and no counter logic is built; all other behaviour is unchanged.

Verification
REQ-040 NUM_FILTERS=4, PIPE_LAT=3, T=8, single left strobe with sample 0x123456 -> mac_start at cycle 1, 32 tap-valid cycles, l_done at cycle 37, mac_sample=0x123456, mac_chan=0.
REQ-041 Left and right strobed in the same cycle -> left served first, then right; r_done arrives 38 cycles after l_done.
REQ-042 Two left strobes during RUN (T=8) -> overrun[0]=1 and the second sample is served next; with the macro defined, overrun_cnt=1.
REQ-043 taps_per_filter=0 -> behaves as T=1: 4 tap-valid cycles and done at cycle 9.
REQ-044 audio_en dropped at RUN cycle 10 -> IDLE next cycle, no done strobe, busy=0, pending cleared.
REQ-045 reset=1 for one cycle during DRAIN -> all outputs 0 next cycle; a subsequent right strobe is served normally.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Sequences one shared FIR MAC across the left/right audio channels, one job per sample.
// Define SCHED_OVERRUN_CNT_EN to build the saturating overrun event counter.
module fir_channel_scheduler #(
   parameter int NUM_FILTERS = 4,
   parameter int PIPE_LAT    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        audio_en,
   input  logic [7:0]  taps_per_filter,
   input  logic        l_data_en,
   input  logic        r_data_en,
   input  logic [23:0] l_data_in,
   input  logic [23:0] r_data_in,
   output logic        mac_start,
   output logic        mac_chan,
   output logic [3:0]  mac_filter,
   output logic [7:0]  mac_tap,
   output logic        mac_tap_valid,
   output logic [23:0] mac_sample,
   output logic        l_done,
   output logic        r_done,
   output logic        busy,
   output logic [1:0]  overrun,
   output logic [7:0]  overrun_cnt
);

   localparam logic [3:0] LAST_FILTER = 4'(NUM_FILTERS - 1);
   localparam logic [3:0] LAST_DRAIN  = 4'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  pending_q, pending_d;
   logic        last_served_q, last_served_d;
   logic [23:0] hold_l_q, hold_l_d;
   logic [23:0] hold_r_q, hold_r_d;
   logic        cur_chan_q, cur_chan_d;
   logic [7:0]  t_q, t_d;
   logic [3:0]  filter_q, filter_d;
   logic [7:0]  tap_q, tap_d;
   logic [3:0]  drain_q, drain_d;
   logic        mac_start_q, mac_start_d;
   logic        mac_chan_q, mac_chan_d;
   logic        mac_tap_valid_q, mac_tap_valid_d;
   logic [23:0] mac_sample_q, mac_sample_d;
   logic        l_done_q, l_done_d;
   logic        r_done_q, r_done_d;
   logic        busy_q, busy_d;
   logic [1:0]  overrun_q, overrun_d;

   logic [1:0]  strobe_s;
   logic [1:0]  pend_eff_s;
   logic        sel_chan_s;
   logic [23:0] sel_sample_s;

   // Arbitration: a strobe in this cycle counts as pending so IDLE can launch at once.
   always_comb begin
      strobe_s   = {r_data_en, l_data_en} & {2{audio_en}};
      pend_eff_s = pending_q | strobe_s;
      if (pend_eff_s == 2'b11) begin
         sel_chan_s = ~last_served_q;
      end else if (pend_eff_s[1]) begin
         sel_chan_s = 1'b1;
      end else begin
         sel_chan_s = 1'b0;
      end
      if (sel_chan_s) begin
         sel_sample_s = pending_q[1] ? hold_r_q : r_data_in;
      end else begin
         sel_sample_s = pending_q[0] ? hold_l_q : l_data_in;
      end
   end

   // Next-state and registered-output logic for the sweep FSM.
   always_comb begin
      state_d         = state_q;
      pending_d       = pending_q;
      last_served_d   = last_served_q;
      hold_l_d        = hold_l_q;
      hold_r_d        = hold_r_q;
      cur_chan_d      = cur_chan_q;
      t_d             = t_q;
      filter_d        = filter_q;
      tap_d           = tap_q;
      drain_d         = drain_q;
      mac_start_d     = 1'b0;
      mac_chan_d      = mac_chan_q;
      mac_tap_valid_d = 1'b0;
      mac_sample_d    = mac_sample_q;
      l_done_d        = 1'b0;
      r_done_d        = 1'b0;
      overrun_d       = overrun_q;

      if (audio_en) begin
         if (strobe_s[0]) begin
            hold_l_d = l_data_in;
         end else begin
            hold_l_d = hold_l_q;
         end
         if (strobe_s[1]) begin
            hold_r_d = r_data_in;
         end else begin
            hold_r_d = hold_r_q;
         end
         pending_d = pending_q | strobe_s;
         overrun_d = overrun_q | (strobe_s & pending_q);

         case (state_q)
            IDLE: begin
               if (pend_eff_s != 2'b00) begin
                  // A same-cycle strobe on an already-pending channel stays queued.
                  pending_d[sel_chan_s] = pending_q[sel_chan_s] & strobe_s[sel_chan_s];
                  cur_chan_d   = sel_chan_s;
                  mac_sample_d = sel_sample_s;
                  mac_start_d  = 1'b1;
                  state_d      = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD: begin
               t_d             = (taps_per_filter == 8'd0) ? 8'd1 : taps_per_filter;
               filter_d        = 4'd0;
               tap_d           = 8'd0;
               mac_chan_d      = cur_chan_q;
               mac_tap_valid_d = 1'b1;
               state_d         = RUN;
            end
            RUN: begin
               if (tap_q == (t_q - 8'd1)) begin
                  if (filter_q == LAST_FILTER) begin
                     drain_d = 4'd0;
                     state_d = DRAIN;
                  end else begin
                     filter_d        = filter_q + 4'd1;
                     tap_d           = 8'd0;
                     mac_tap_valid_d = 1'b1;
                  end
               end else begin
                  tap_d           = tap_q + 8'd1;
                  mac_tap_valid_d = 1'b1;
               end
            end
            DRAIN: begin
               if (drain_q == LAST_DRAIN) begin
                  l_done_d = ~cur_chan_q;
                  r_done_d = cur_chan_q;
                  state_d  = DONE;
               end else begin
                  drain_d = drain_q + 4'd1;
               end
            end
            DONE: begin
               last_served_d = cur_chan_q;
               state_d       = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d   = IDLE;
         pending_d = 2'b00;
         overrun_d = 2'b00;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         pending_q       <= 2'b00;
         last_served_q   <= 1'b1;
         hold_l_q        <= 24'd0;
         hold_r_q        <= 24'd0;
         cur_chan_q      <= 1'b0;
         t_q             <= 8'd0;
         filter_q        <= 4'd0;
         tap_q           <= 8'd0;
         drain_q         <= 4'd0;
         mac_start_q     <= 1'b0;
         mac_chan_q      <= 1'b0;
         mac_tap_valid_q <= 1'b0;
         mac_sample_q    <= 24'd0;
         l_done_q        <= 1'b0;
         r_done_q        <= 1'b0;
         busy_q          <= 1'b0;
         overrun_q       <= 2'b00;
      end else begin
         state_q         <= state_d;
         pending_q       <= pending_d;
         last_served_q   <= last_served_d;
         hold_l_q        <= hold_l_d;
         hold_r_q        <= hold_r_d;
         cur_chan_q      <= cur_chan_d;
         t_q             <= t_d;
         filter_q        <= filter_d;
         tap_q           <= tap_d;
         drain_q         <= drain_d;
         mac_start_q     <= mac_start_d;
         mac_chan_q      <= mac_chan_d;
         mac_tap_valid_q <= mac_tap_valid_d;
         mac_sample_q    <= mac_sample_d;
         l_done_q        <= l_done_d;
         r_done_q        <= r_done_d;
         busy_q          <= busy_d;
         overrun_q       <= overrun_d;
      end
   end

`ifdef SCHED_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt_q, overrun_cnt_d;
   logic [8:0] cnt_sum_s;

   // Saturating count of overrun events; both channels in one cycle add two.
   always_comb begin
      cnt_sum_s = {1'b0, overrun_cnt_q}
                + {8'd0, strobe_s[0] & pending_q[0]}
                + {8'd0, strobe_s[1] & pending_q[1]};
      if (cnt_sum_s > 9'd255) begin
         overrun_cnt_d = 8'd255;
      end else begin
         overrun_cnt_d = cnt_sum_s[7:0];
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_cnt_q <= 8'd0;
      end else begin
         overrun_cnt_q <= overrun_cnt_d;
      end
   end

   assign overrun_cnt = overrun_cnt_q;
`else
   assign overrun_cnt = 8'd0;
`endif

   assign mac_start     = mac_start_q;
   assign mac_chan      = mac_chan_q;
   assign mac_filter    = filter_q;
   assign mac_tap       = tap_q;
   assign mac_tap_valid = mac_tap_valid_q;
   assign mac_sample    = mac_sample_q;
   assign l_done        = l_done_q;
   assign r_done        = r_done_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: directed vector table, corner sequences, and a random
// run, all shadowed cycle by cycle by a job-level reference model.
module tb_fir_channel_scheduler;
   localparam int NF = 4;
   localparam int PL = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        audio_en = 1'b0;
   logic [7:0]  taps = 8'd8;
   logic        l_data_en = 1'b0;
   logic        r_data_en = 1'b0;
   logic [23:0] l_data_in = 24'd0;
   logic [23:0] r_data_in = 24'd0;
   logic        mac_start, mac_chan, mac_tap_valid, l_done, r_done, busy;
   logic [3:0]  mac_filter;
   logic [7:0]  mac_tap, overrun_cnt;
   logic [23:0] mac_sample;
   logic [1:0]  overrun;

   always #5 clk = ~clk;

   fir_channel_scheduler #(.NUM_FILTERS(NF), .PIPE_LAT(PL)) dut (
      .clk(clk), .reset(reset), .audio_en(audio_en), .taps_per_filter(taps),
      .l_data_en(l_data_en), .r_data_en(r_data_en),
      .l_data_in(l_data_in), .r_data_in(r_data_in),
      .mac_start(mac_start), .mac_chan(mac_chan), .mac_filter(mac_filter),
      .mac_tap(mac_tap), .mac_tap_valid(mac_tap_valid), .mac_sample(mac_sample),
      .l_done(l_done), .r_done(r_done), .busy(busy),
      .overrun(overrun), .overrun_cnt(overrun_cnt)
   );

   logic [51:0] dut_vec;
   assign dut_vec = {mac_start, mac_chan, mac_filter, mac_tap, mac_tap_valid, mac_sample,
                     l_done, r_done, busy, overrun, overrun_cnt};

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Job-level reference model: a job is described by its start and a cycle offset.
   bit          m_active, m_jchan, m_last, m_chan;
   int          m_off, m_T, m_cnt, m_filt, m_tap;
   bit   [1:0]  m_pend, m_ovr;
   logic [23:0] m_sample;
   logic [23:0] m_held [2];
   logic [51:0] exp_vec;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   task automatic model_step();
      logic [1:0]  s, eff, np;
      logic        sel, st, val, ld, rd;
      logic [7:0]  cnt8;
      logic [23:0] din [2];
      int          nt;
      if (reset) begin
         m_active = 1'b0; m_off = 0; m_T = 1; m_jchan = 1'b0; m_pend = 2'b00;
         m_ovr = 2'b00; m_cnt = 0; m_last = 1'b1; m_sample = 24'd0;
         m_held[0] = 24'd0; m_held[1] = 24'd0; m_chan = 1'b0; m_filt = 0; m_tap = 0;
      end else if (!audio_en) begin
         m_active = 1'b0; m_pend = 2'b00; m_ovr = 2'b00;
      end else begin
         s = {r_data_en, l_data_en};
         din[0] = l_data_in;
         din[1] = r_data_in;
         for (int c = 0; c < 2; c++) begin
            if (s[c] && m_pend[c]) begin
               m_ovr[c] = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         if (m_active) begin
            nt = NF * m_T;
            if (m_off == nt + PL + 1) begin
               m_active = 1'b0;
               m_last   = m_jchan;
            end else begin
               if (m_off == 0) m_T = (taps == 8'd0) ? 1 : int'(taps);
               m_off++;
            end
            m_pend = m_pend | s;
         end else begin
            eff = m_pend | s;
            if (eff != 2'b00) begin
               sel      = (eff == 2'b11) ? ~m_last : eff[1];
               m_sample = m_pend[sel] ? m_held[sel] : din[sel];
               np       = eff;
               np[sel]  = m_pend[sel] & s[sel];
               m_pend   = np;
               m_jchan  = sel;
               m_active = 1'b1;
               m_off    = 0;
            end
         end
         for (int c = 0; c < 2; c++) begin
            if (s[c]) m_held[c] = din[c];
         end
      end
      nt  = NF * m_T;
      st  = m_active && (m_off == 0);
      val = m_active && (m_off >= 1) && (m_off <= nt);
      if (val) begin
         m_filt = (m_off - 1) / m_T;
         m_tap  = (m_off - 1) % m_T;
         m_chan = m_jchan;
      end
      ld = m_active && (m_off == nt + PL + 1) && !m_jchan;
      rd = m_active && (m_off == nt + PL + 1) && m_jchan;
`ifdef SCHED_OVERRUN_CNT_EN
      cnt8 = 8'(m_cnt);
`else
      cnt8 = 8'd0;
`endif
      exp_vec = {st, m_chan, 4'(m_filt), 8'(m_tap), val, m_sample, ld, rd, m_active, m_ovr, cnt8};
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("lockstep", {12'd0, dut_vec}, {12'd0, exp_vec});
   endtask

   task automatic do_reset();
      reset = 1'b1; l_data_en = 1'b0; r_data_en = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  taps;
      logic        ls;
      logic        rs;
      logic [23:0] ld;
      logic [23:0] rd;
      int          l_at;
      int          r_at;
      int          n_valid;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int first_start, l_at, r_at, nval, starts, dones, r0;
      bit chanf, busy12, valid12, busy_late, l_seen;
      logic [23:0] samp, samp2;
      logic [7:0] exp_cnt;

      vecs[0] = '{8'd8, 1'b1, 1'b0, 24'h123456, 24'h000000, 37, -1, 32};
      vecs[1] = '{8'd8, 1'b1, 1'b1, 24'hABCDEF, 24'h654321, 37, 75, 64};
      vecs[2] = '{8'd0, 1'b1, 1'b0, 24'h0F0F0F, 24'h000000,  9, -1,  4};
      vecs[3] = '{8'd1, 1'b0, 1'b1, 24'h000000, 24'h0FEDCB, -1,  9,  4};
      vecs[4] = '{8'd3, 1'b0, 1'b1, 24'h000000, 24'hC0FFEE, -1, 17, 12};
      vecs[5] = '{8'd2, 1'b1, 1'b1, 24'h111111, 24'h222222, 13, 27, 16};

      do_reset();
      chk("reset_state", {12'd0, dut_vec}, 64'd0);
      audio_en = 1'b1;

      for (int v = 0; v < 6; v++) begin
         do_reset();
         taps = vecs[v].taps;
         l_data_in = vecs[v].ld; r_data_in = vecs[v].rd;
         l_data_en = vecs[v].ls; r_data_en = vecs[v].rs;
         cyc = 0;
         tick();
         l_data_en = 1'b0; r_data_en = 1'b0;
         first_start = -1; l_at = -1; r_at = -1; nval = 0; samp = 24'd0; chanf = 1'b0;
         for (int k = 0; k < 100; k++) begin
            if (mac_start && first_start < 0) begin first_start = cyc; samp = mac_sample; end
            if (mac_tap_valid) begin
               if (nval == 0) chanf = mac_chan;
               nval++;
            end
            if (l_done && l_at < 0) l_at = cyc;
            if (r_done && r_at < 0) r_at = cyc;
            tick();
         end
         chk("vec_start_cycle", 64'(first_start), 64'(1));
         chk("vec_sample", 64'(samp), 64'(vecs[v].ls ? vecs[v].ld : vecs[v].rd));
         chk("vec_first_chan", 64'(chanf), 64'(!vecs[v].ls));
         chk("vec_l_done_cycle", 64'(l_at), 64'(vecs[v].l_at));
         chk("vec_r_done_cycle", 64'(r_at), 64'(vecs[v].r_at));
         chk("vec_valid_count", 64'(nval), 64'(vecs[v].n_valid));
      end

      // Overrun: second and third left strobes during RUN; the last one is served next.
      do_reset();
      taps = 8'd8; l_data_in = 24'hAAAAAA; l_data_en = 1'b1; cyc = 0;
      tick();
      starts = 0; samp2 = 24'd0;
      for (int k = 0; k < 45; k++) begin
         if (mac_start) begin
            starts++;
            if (starts == 2) samp2 = mac_sample;
         end
         l_data_en = (cyc == 5) || (cyc == 10);
         l_data_in = (cyc == 5) ? 24'hBBBBBB : 24'hCCCCCC;
         tick();
      end
      l_data_en = 1'b0;
`ifdef SCHED_OVERRUN_CNT_EN
      exp_cnt = 8'd1;
`else
      exp_cnt = 8'd0;
`endif
      chk("ovr_flag", 64'(overrun), 64'(2'b01));
      chk("ovr_cnt", 64'(overrun_cnt), 64'(exp_cnt));
      chk("ovr_second_sample", 64'(samp2), 64'(24'hCCCCCC));

      // audio_en dropped mid-RUN: abort, no done, pending right sample discarded.
      do_reset();
      taps = 8'd8; l_data_in = 24'h135790; l_data_en = 1'b1; cyc = 0;
      tick();
      l_data_en = 1'b0;
      dones = 0; busy12 = 1'b1; valid12 = 1'b1; busy_late = 1'b0;
      for (int k = 0; k < 70; k++) begin
         if (l_done || r_done) dones++;
         if (cyc == 12) begin busy12 = busy; valid12 = mac_tap_valid; end
         if (cyc > 12 && busy) busy_late = 1'b1;
         r_data_en = (cyc == 3);
         r_data_in = 24'h246802;
         audio_en  = (cyc != 11);
         tick();
      end
      r_data_en = 1'b0; audio_en = 1'b1;
      chk("abort_busy", 64'(busy12), 64'(0));
      chk("abort_valid", 64'(valid12), 64'(0));
      chk("abort_no_done", 64'(dones), 64'(0));
      chk("abort_pending_cleared", 64'(busy_late), 64'(0));

      // Reset pulse in DRAIN, then a right job runs normally.
      do_reset();
      taps = 8'd2; l_data_in = 24'h5A5A5A; l_data_en = 1'b1; cyc = 0;
      tick();
      l_data_en = 1'b0;
      while (cyc < 11) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("drain_reset_zero", {12'd0, dut_vec}, 64'd0);
      r_data_in = 24'h777777; r_data_en = 1'b1; r0 = cyc;
      tick();
      r_data_en = 1'b0;
      r_at = -1; l_seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (r_done && r_at < 0) r_at = cyc - r0;
         if (l_done) l_seen = 1'b1;
         tick();
      end
      chk("post_reset_r_latency", 64'(r_at), 64'(13));
      chk("post_reset_no_l_done", 64'(l_seen), 64'(0));
      chk("post_reset_sample", 64'(mac_sample), 64'(24'h777777));

      // Random traffic checked cycle by cycle against the model.
      audio_en = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         reset     = ($urandom_range(599) == 0);
         audio_en  = ($urandom_range(199) != 0);
         l_data_en = ($urandom_range(24) == 0);
         r_data_en = ($urandom_range(24) == 0);
         l_data_in = 24'($urandom);
         r_data_in = 24'($urandom);
         if ($urandom_range(49) == 0) taps = 8'($urandom_range(4));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
